// File: rtl/mat_pkg.sv
// Shared encodings for the matrix-op sequencer.
// Unit enable indices double as ReadWrite bit indices.
package mat_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WR,
    S_DONE,
    S_ERR
  } state_t;

  localparam int EN_RAM  = 0;
  localparam int EN_REG  = 1;
  localparam int EN_ALU  = 2;
  localparam int EN_INST = 3;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int OP_UNARY = 7;

  typedef struct packed {
    logic [7:0] op;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst;
    logic       wr_reg;
  } op_t;

endpackage

// File: rtl/mat_timeout_ctr.sv
// Counts EXEC cycles; tc marks the cycle that is the MAX-th one.
// Holds at the terminal value until cleared.
module mat_timeout_ctr #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mat_op_sequencer.sv
// Sequences one matrix op: read operands, run ALU, write result.
// All outputs are registered from the current state (Moore).
module mat_op_sequencer
  import mat_pkg::*;
#(
  parameter int ALU_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [7:0]       OpIn,
  input  logic [3:0]       SrcA,
  input  logic [3:0]       SrcB,
  input  logic [3:0]       Dst,
  input  logic             WrReg,
  input  logic             Status,
  output logic [3:0]       Enable,
  output logic [2:0]       ReadWrite,
  output logic [3:0]       Address,
  output logic [7:0]       Opcode,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] OpCount
);

  state_t state_q;
  state_t state_d;
  op_t    op_q;
  logic   tc;

  logic [3:0] en_d;
  logic [2:0] rw_d;
  logic [3:0] addr_d;
  logic [7:0] opc_d;
  logic       busy_d;
  logic       done_d;
  logic       err_d;

  mat_timeout_ctr #(
    .MAX (ALU_TIMEOUT)
  ) u_tmo (
    .clk   (Clock),
    .rst_n (Reset_n),
    .clr   (state_q != S_EXEC),
    .en    (state_q == S_EXEC),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (Start) state_d = S_RD_A;
      S_RD_A: state_d = op_q.op[OP_UNARY] ? S_EXEC : S_RD_B;
      S_RD_B: state_d = S_EXEC;
      S_EXEC: begin
        // Status wins over a coincident timeout
        if (Status)  state_d = S_WR;
        else if (tc) state_d = S_ERR;
      end
      S_WR:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    en_d   = '0;
    rw_d   = '0;
    addr_d = '0;
    opc_d  = '0;
    busy_d = (state_q != S_IDLE);
    done_d = 1'b0;
    err_d  = 1'b0;
    unique case (state_q)
      S_RD_A, S_RD_B: begin
        en_d[EN_RAM] = 1'b1;
        en_d[EN_ALU] = 1'b1;
        rw_d[EN_RAM] = RW_READ;
        rw_d[EN_ALU] = RW_WRITE;
        addr_d = (state_q == S_RD_A) ? op_q.src_a : op_q.src_b;
      end
      S_EXEC: begin
        en_d[EN_ALU] = 1'b1;
        rw_d[EN_ALU] = RW_READ;
        opc_d = op_q.op;
      end
      S_WR: begin
        en_d[EN_RAM] = 1'b1;
        en_d[EN_REG] = op_q.wr_reg;
        en_d[EN_ALU] = 1'b1;
        rw_d[EN_RAM] = RW_WRITE;
        rw_d[EN_REG] = RW_WRITE;
        rw_d[EN_ALU] = RW_READ;
        addr_d = op_q.dst;
      end
      S_DONE: done_d = 1'b1;
      S_ERR:  err_d  = 1'b1;
      default: ;
    endcase
    en_d[EN_INST] = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      Enable    <= '0;
      ReadWrite <= '0;
      Address   <= '0;
      Opcode    <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      OpCount   <= '0;
    end else begin
      state_q   <= state_d;
      Enable    <= en_d;
      ReadWrite <= rw_d;
      Address   <= addr_d;
      Opcode    <= opc_d;
      Busy      <= busy_d;
      Done      <= done_d;
      Error     <= err_d;
      if (state_q == S_IDLE && Start) begin
        op_q <= '{op: OpIn, src_a: SrcA, src_b: SrcB,
                  dst: Dst, wr_reg: WrReg};
      end
      if (state_q == S_DONE) OpCount <= OpCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mat_op_sequencer.sv
// Random and directed checks of mat_op_sequencer against a
// plan-queue model of each op's per-cycle unit activity.
module tb_mat_op_sequencer;

  localparam int TO = 16;
  localparam int CW = 4;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0;
  logic [7:0]    OpIn = '0;
  logic [3:0]    SrcA = '0;
  logic [3:0]    SrcB = '0;
  logic [3:0]    Dst = '0;
  logic          WrReg = 1'b0;
  logic          Status = 1'b0;
  logic [3:0]    Enable;
  logic [2:0]    ReadWrite;
  logic [3:0]    Address;
  logic [7:0]    Opcode;
  logic          Busy;
  logic          Done;
  logic          Error;
  logic [CW-1:0] OpCount;

  mat_op_sequencer #(.ALU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .OpIn(OpIn),
    .SrcA(SrcA), .SrcB(SrcB), .Dst(Dst), .WrReg(WrReg),
    .Status(Status), .Enable(Enable), .ReadWrite(ReadWrite),
    .Address(Address), .Opcode(Opcode), .Busy(Busy), .Done(Done),
    .Error(Error), .OpCount(OpCount)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a queue of cycle activities still to perform for the op.
  localparam int K_RD = 1, K_EXEC = 2, K_WR = 3, K_DONE = 4, K_ERR = 5;
  typedef struct {
    logic [3:0] en;
    logic [2:0] rw;
    logic [3:0] addr;
    logic [7:0] opc;
    int         kind;
  } rec_t;

  rec_t          plan[$];
  rec_t          cur;
  int            exec_n;
  logic [7:0]    m_op;
  logic [3:0]    m_b, m_d;
  logic          m_wr;
  logic [CW-1:0] m_cnt;
  logic [3:0]    e_en;
  logic [2:0]    e_rw;
  logic [3:0]    e_addr;
  logic [7:0]    e_opc;
  logic          e_busy, e_done, e_err;

  function automatic rec_t mk(input logic [3:0] en, input logic [2:0] rw,
                              input logic [3:0] a, input logic [7:0] o,
                              input int k);
    rec_t r;
    r.en = en; r.rw = rw; r.addr = a; r.opc = o; r.kind = k;
    return r;
  endfunction

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      plan.delete();
      exec_n = 0; m_cnt = '0;
      e_en = '0; e_rw = '0; e_addr = '0; e_opc = '0;
      e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      cur = (plan.size() == 0) ? mk(4'h0, 3'h0, 4'h0, 8'h0, 0) : plan[0];
      e_en = cur.en; e_rw = cur.rw; e_addr = cur.addr; e_opc = cur.opc;
      e_busy = (plan.size() != 0);
      e_done = (cur.kind == K_DONE);
      e_err  = (cur.kind == K_ERR);
      if (cur.kind == K_DONE) m_cnt = m_cnt + 1'b1;
      if (plan.size() == 0) begin
        if (Start) begin
          m_op = OpIn; m_b = SrcB; m_d = Dst; m_wr = WrReg;
          plan.push_back(mk(4'b0101, 3'b001, SrcA, 8'h0, K_RD));
          if (!OpIn[7]) plan.push_back(mk(4'b0101, 3'b001, SrcB, 8'h0, K_RD));
          plan.push_back(mk(4'b0100, 3'b100, 4'h0, OpIn, K_EXEC));
          exec_n = 0;
        end
      end else if (cur.kind == K_EXEC) begin
        exec_n++;
        if (Status) begin
          void'(plan.pop_front());
          plan.push_back(mk({2'b01, m_wr, 1'b1}, 3'b100, m_d, 8'h0, K_WR));
          plan.push_back(mk(4'h0, 3'h0, 4'h0, 8'h0, K_DONE));
        end else if (exec_n == TO) begin
          void'(plan.pop_front());
          plan.push_back(mk(4'h0, 3'h0, 4'h0, 8'h0, K_ERR));
        end
      end else begin
        void'(plan.pop_front());
      end
    end
  end

  logic [25:0] act_v, exp_v;
  always @(negedge Clock) begin
    if (Reset_n) begin
      act_v = {Enable, ReadWrite, Address, Opcode, Busy, Done, Error, OpCount};
      exp_v = {e_en, e_rw, e_addr, e_opc, e_busy, e_done, e_err, m_cnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle @%0t: got %h expected %h", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [3:0]    c_en[0:24];
  logic [2:0]    c_rw[0:24];
  logic [3:0]    c_addr[0:24];
  logic [7:0]    c_opc[0:24];
  logic          c_busy[0:24];
  logic          c_done[0:24];
  logic          c_err[0:24];
  logic [CW-1:0] c_cnt[0:24];

  task automatic setup(input logic [7:0] op, input logic [3:0] a, b, d,
                       input logic wr, input logic st);
    OpIn = op; SrcA = a; SrcB = b; Dst = d; WrReg = wr;
    Status = st; Start = 1'b1;
  endtask

  // k = outputs seen after the k-th edge following the Start sample.
  task automatic run_cap(input int n, input int hold_k, input int st_k);
    for (int k = 0; k <= n; k++) begin
      @(negedge Clock);
      c_en[k] = Enable; c_rw[k] = ReadWrite; c_addr[k] = Address;
      c_opc[k] = Opcode; c_busy[k] = Busy; c_done[k] = Done;
      c_err[k] = Error; c_cnt[k] = OpCount;
      Start = (k < hold_k);
      Status = (k >= st_k);
    end
  endtask

  int n_exec, n_wr, n_err;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge Clock);
    chk("reset_outs", {Enable, ReadWrite, Address, Opcode, Busy, Done,
                       Error, OpCount}, 0);
    Reset_n = 1'b1;

    setup(8'h01, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1);
    run_cap(6, 0, 0);
    chk("bin_addr1", c_addr[1], 2);
    chk("bin_addr2", c_addr[2], 3);
    chk("bin_rd_en", {c_en[1], c_rw[1]}, {4'b0101, 3'b001});
    chk("bin_exec", {c_en[3], c_rw[3], c_opc[3]}, {4'b0100, 3'b100, 8'h01});
    chk("bin_wr", {c_en[4], c_rw[4], c_addr[4]}, {4'b0101, 3'b100, 4'd4});
    chk("bin_done_lat", {c_done[4], c_done[5], c_done[6]}, 3'b010);
    chk("bin_cnt", c_cnt[5], 1);
    chk("bin_busy_end", {c_busy[5], c_busy[6]}, 2'b10);

    setup(8'h81, 4'd5, 4'd9, 4'd6, 1'b0, 1'b1);
    run_cap(5, 0, 0);
    chk("un_addr", {c_addr[1], c_en[2], c_addr[3]}, {4'd5, 4'b0100, 4'd6});
    chk("un_done_lat", {c_done[3], c_done[4], c_done[5]}, 3'b010);

    setup(8'h22, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
    run_cap(21, 0, 99);
    n_exec = 0; n_wr = 0; n_err = 0;
    for (int k = 1; k <= 21; k++) begin
      if (c_en[k] == 4'b0100) n_exec++;
      if (c_en[k][0] && c_rw[k] == 3'b100) n_wr++;
      if (c_err[k]) n_err++;
    end
    chk("tmo_exec_cycles", n_exec, 16);
    chk("tmo_no_wr", n_wr, 0);
    chk("tmo_err", {c_err[18], c_err[19], c_err[20]}, 3'b010);
    chk("tmo_err_count", n_err, 1);
    chk("tmo_busy", {c_busy[19], c_busy[20]}, 2'b10);
    chk("tmo_cnt", c_cnt[20], 2);

    setup(8'h03, 4'd7, 4'd8, 4'd9, 1'b1, 1'b0);
    run_cap(9, 0, 5);
    n_exec = 0;
    for (int k = 1; k <= 9; k++) if (c_en[k] == 4'b0100) n_exec++;
    chk("dly_exec_cycles", n_exec, 4);
    chk("dly_wr", {c_en[7], c_rw[7], c_addr[7]}, {4'b0111, 3'b100, 4'd9});
    chk("dly_done", c_done[8], 1);
    chk("dly_cnt", c_cnt[8], 3);

    setup(8'h04, 4'd1, 4'd1, 4'd1, 1'b1, 1'b0);
    run_cap(5, 0, 99);
    #2 Reset_n = 1'b0;
    #1 chk("rst_mid_exec", {Enable, ReadWrite, Address, Opcode, Busy, Done,
                            Error, OpCount}, 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    setup(8'h85, 4'd10, 4'd0, 4'd11, 1'b0, 1'b1);
    run_cap(5, 0, 0);
    chk("post_rst_done", {c_done[4], c_addr[3]}, {1'b1, 4'd11});
    chk("post_rst_cnt", c_cnt[4], 1);

    for (int i = 0; i < 14; i++) begin
      setup(8'h10, 4'(i), 4'(i + 1), 4'(i + 2), 1'b0, 1'b1);
      run_cap(6, 0, 0);
    end
    chk("preload_cnt", OpCount, 15);

    setup(8'h02, 4'd12, 4'd13, 4'd14, 1'b0, 1'b1);
    run_cap(13, 11, 0);
    chk("hold_wrap", {c_done[5], c_cnt[5]}, {1'b1, 4'd0});
    chk("hold_gap", {c_busy[6], c_busy[7], c_addr[7]}, {1'b0, 1'b1, 4'd12});
    chk("hold_second", {c_done[11], c_cnt[11], c_busy[13]}, {1'b1, 4'd1, 1'b0});

    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      if ($urandom_range(0, 499) == 0) begin
        #2 Reset_n = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
      end
      Start  = ($urandom_range(0, 2) == 0);
      OpIn   = 8'($urandom);
      SrcA   = 4'($urandom);
      SrcB   = 4'($urandom);
      Dst    = 4'($urandom);
      WrReg  = 1'($urandom);
      Status = ($urandom_range(0, 3) == 0);
    end
    @(negedge Clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
